adc_capture_buffer: RTL and testbench

- Parametrised multi-channel snapshot buffer for RFDC ADC AXI4-Stream outputs; generalises the fixed 8x128-bit channel set to NCHAN channels of DWIDTH bits.
- Continuously records into per-channel circular RAMs once armed. On trigger, completes a capture with a programmable pre-trigger length.
- Exposes a trigger-relative read port for the register block. All logic runs in the ADC stream clock domain; any CDC lives outside this block.

---
 rtl/adc_capture_pkg.sv | 13 +
 rtl/capture_ram.sv | 28 ++
 rtl/adc_capture_buffer.sv | 171 +++++++++++++++++
 tb/tb_adc_capture_buffer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types for the ADC snapshot capture buffer: capture FSM states and counter widths.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_TRIGGERED = 2'd2,
        ST_DONE      = 2'd3
    } cap_state_e;

    localparam int TRIG_CNT_W = 16;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port (maps onto BRAM/URAM).
module capture_ram #(
    parameter  int DWIDTH = 128,
    parameter  int DEPTH  = 1024,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    // No reset on the array or the read register so the tools can use block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/adc_capture_buffer.sv
// Multi-channel ADC snapshot buffer: circular recording once armed, trigger with programmable
// pre-trigger depth, and a trigger-relative read port with 2-cycle latency.
module adc_capture_buffer
    import adc_capture_pkg::*;
#(
    parameter  int NCHAN  = 8,
    parameter  int DWIDTH = 128,
    parameter  int DEPTH  = 1024,
    localparam int AW     = $clog2(DEPTH),
    localparam int CHW    = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NCHAN*DWIDTH-1:0] adc_tdata,
    input  logic                    adc_tvalid,
    input  logic [NCHAN-1:0]        chan_mask_i,
    input  logic [AW-1:0]           pretrig_i,
    input  logic                    arm_i,
    input  logic                    trig_i,
    input  logic                    abort_i,
    output logic [1:0]              state_o,
    output logic                    done_o,
    output logic [AW-1:0]           start_addr_o,
    output logic [TRIG_CNT_W-1:0]   trig_count_o,
    input  logic [CHW-1:0]          rd_chan_i,
    input  logic [AW-1:0]           rd_addr_i,
    input  logic                    rd_en_i,
    output logic [DWIDTH-1:0]       rd_data_o,
    output logic                    rd_valid_o
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    cap_state_e              state_q;
    logic [NCHAN-1:0]        mask_q;
    logic [AW-1:0]           pretrig_q;
    logic [AW-1:0]           wr_ptr_q;
    logic [AW-1:0]           start_addr_q;
    logic [AW:0]             fill_cnt_q;
    logic [AW:0]             post_cnt_q;
    logic [TRIG_CNT_W-1:0]   trig_count_q;
    logic                    done_q;

    logic                    wr_en;
    logic                    trig_ok;
    logic [AW-1:0]           rd_phys;

    // Abort wins over everything, including the beat presented in the abort cycle.
    always_comb begin
        wr_en   = 1'b0;
        trig_ok = 1'b0;
        if (!abort_i && adc_tvalid) begin
            wr_en = (state_q == ST_ARMED) ||
                    ((state_q == ST_TRIGGERED) && (post_cnt_q != '0));
        end
        if (!abort_i && trig_i && (state_q == ST_ARMED)) begin
            trig_ok = (fill_cnt_q >= {1'b0, pretrig_q});
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            pretrig_q    <= '0;
            wr_ptr_q     <= '0;
            start_addr_q <= '0;
            fill_cnt_q   <= '0;
            post_cnt_q   <= '0;
            trig_count_q <= '0;
            done_q       <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (abort_i) begin
                state_q <= ST_IDLE;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (arm_i) begin
                            mask_q     <= chan_mask_i;
                            pretrig_q  <= pretrig_i;
                            fill_cnt_q <= '0;
                            done_q     <= 1'b0;
                            state_q    <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (adc_tvalid && (fill_cnt_q != DEPTH_W)) begin
                            fill_cnt_q <= fill_cnt_q + 1'b1;
                        end
                        if (trig_ok) begin
                            start_addr_q <= wr_ptr_q - pretrig_q;
                            // The trigger-cycle beat, when valid, is already the first post beat.
                            post_cnt_q   <= DEPTH_W - {1'b0, pretrig_q} - {{AW{1'b0}}, adc_tvalid};
                            if (trig_count_q != '1) begin
                                trig_count_q <= trig_count_q + 1'b1;
                            end
                            state_q <= ST_TRIGGERED;
                        end
                    end
                    ST_TRIGGERED: begin
                        if (post_cnt_q == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (adc_tvalid) begin
                            post_cnt_q <= post_cnt_q - 1'b1;
                            if (post_cnt_q == (AW+1)'(1)) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign state_o      = state_q;
    assign done_o       = done_q;
    assign start_addr_o = start_addr_q;
    assign trig_count_o = trig_count_q;

    // Read port: every rd_en_i strobe yields exactly one rd_valid_o pulse two cycles later,
    // with no backpressure; strobes may be issued on consecutive cycles.
    assign rd_phys = start_addr_q + rd_addr_i;

    logic [DWIDTH-1:0] ram_rdata [NCHAN];
    logic              rd_en_d1;
    logic [CHW-1:0]    rd_chan_d1;
    logic [DWIDTH-1:0] rd_data_q;
    logic              rd_valid_q;

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        capture_ram #(
            .DWIDTH (DWIDTH),
            .DEPTH  (DEPTH)
        ) u_ram (
            .clk    (aclk),
            .we     (wr_en && mask_q[c]),
            .waddr  (wr_ptr_q),
            .wdata  (adc_tdata[c*DWIDTH +: DWIDTH]),
            .re     (rd_en_i),
            .raddr  (rd_phys),
            .rdata  (ram_rdata[c])
        );
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_en_d1   <= 1'b0;
            rd_chan_d1 <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_en_d1   <= rd_en_i;
            rd_chan_d1 <= rd_chan_i;
            rd_valid_q <= rd_en_d1;
            if (rd_en_d1) begin
                rd_data_q <= ram_rdata[rd_chan_d1];
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Self-checking bench for adc_capture_buffer with NCHAN=2, DWIDTH=16, DEPTH=16.
module tb_adc_capture_buffer;

    localparam int NCHAN  = 2;
    localparam int DWIDTH = 16;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;

    logic                    aclk;
    logic                    aresetn;
    logic [NCHAN*DWIDTH-1:0] adc_tdata;
    logic                    adc_tvalid;
    logic [NCHAN-1:0]        chan_mask_i;
    logic [AW-1:0]           pretrig_i;
    logic                    arm_i;
    logic                    trig_i;
    logic                    abort_i;
    logic [1:0]              state_o;
    logic                    done_o;
    logic [AW-1:0]           start_addr_o;
    logic [15:0]             trig_count_o;
    logic [0:0]              rd_chan_i;
    logic [AW-1:0]           rd_addr_i;
    logic                    rd_en_i;
    logic [DWIDTH-1:0]       rd_data_o;
    logic                    rd_valid_o;

    adc_capture_buffer #(
        .NCHAN  (NCHAN),
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .adc_tdata    (adc_tdata),
        .adc_tvalid   (adc_tvalid),
        .chan_mask_i  (chan_mask_i),
        .pretrig_i    (pretrig_i),
        .arm_i        (arm_i),
        .trig_i       (trig_i),
        .abort_i      (abort_i),
        .state_o      (state_o),
        .done_o       (done_o),
        .start_addr_o (start_addr_o),
        .trig_count_o (trig_count_o),
        .rd_chan_i    (rd_chan_i),
        .rd_addr_i    (rd_addr_i),
        .rd_en_i      (rd_en_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o)
    );

    // clock / reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc++;

    // scoreboard
    int n_checks = 0;
    int n_pass   = 0;
    logic [DWIDTH-1:0] exp_q[$];
    int                cyc_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (aresetn && rd_valid_o) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected_valid", 32'd1, 32'd0);
            end else begin
                logic [DWIDTH-1:0] e;
                int c0;
                e  = exp_q.pop_front();
                c0 = cyc_q.pop_front();
                check("rd_data", 32'(rd_data_o), 32'(e));
                check("rd_latency", 32'(cyc - c0), 32'd2);
            end
        end
    end

    // driver tasks
    logic [15:0] ramp = 16'd0;
    int          exp_wr = 0;

    task automatic beat(input logic v, input logic trig, input logic wr);
        adc_tvalid = v;
        adc_tdata  = {16'h8000 + ramp, ramp};
        trig_i     = trig;
        @(posedge aclk);
        #1;
        trig_i     = 1'b0;
        adc_tvalid = 1'b0;
        if (v) ramp++;
        if (wr) exp_wr++;
    endtask

    task automatic arm(input logic [NCHAN-1:0] mask, input logic [AW-1:0] pre);
        arm_i       = 1'b1;
        chan_mask_i = mask;
        pretrig_i   = pre;
        adc_tvalid  = 1'b0;
        @(posedge aclk);
        #1;
        arm_i = 1'b0;
    endtask

    task automatic rd_push(input int ch, input int addr, input logic [DWIDTH-1:0] exp);
        rd_en_i   = 1'b1;
        rd_chan_i = ch[0:0];
        rd_addr_i = addr[AW-1:0];
        exp_q.push_back(exp);
        cyc_q.push_back(cyc);
        @(posedge aclk);
        #1;
    endtask

    task automatic rd_drain(input string tag);
        rd_en_i = 1'b0;
        repeat (4) @(posedge aclk);
        #1;
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_start"}, 32'(start_addr_o), 32'd0);
        check({tag, "_tcnt"}, 32'(trig_count_o), 32'd0);
        check({tag, "_rdv"}, 32'(rd_valid_o), 32'd0);
        check({tag, "_rdd"}, 32'(rd_data_o), 32'd0);
    endtask

    int trig_wr, s3, s4, p;
    logic [15:0] t3, t6, b4;

    initial begin
        aresetn = 1'b0; adc_tdata = '0; adc_tvalid = 1'b0; chan_mask_i = '0;
        pretrig_i = '0; arm_i = 1'b0; trig_i = 1'b0; abort_i = 1'b0;
        rd_chan_i = '0; rd_addr_i = '0; rd_en_i = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check_reset_outputs("reset");
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // 1: pretrig 4, trigger on ramp 10
        arm(2'b11, 4'd4);
        check("t1_armed", 32'(state_o), 32'd1);
        repeat (10) beat(1'b1, 1'b0, 1'b1);
        trig_wr = exp_wr;
        beat(1'b1, 1'b1, 1'b1);
        check("t1_trig_state", 32'(state_o), 32'd2);
        repeat (10) beat(1'b1, 1'b0, 1'b1);
        check("t1_not_done_early", 32'(state_o), 32'd2);
        beat(1'b1, 1'b0, 1'b1);
        check("t1_done_state", 32'(state_o), 32'd3);
        check("t1_done", 32'(done_o), 32'd1);
        check("t1_start", 32'(start_addr_o), 32'((trig_wr - 4) & 15));
        check("t1_start_abs", 32'(start_addr_o), 32'd6);
        check("t1_tcnt", 32'(trig_count_o), 32'd1);
        for (int i = 0; i < 16; i++) rd_push(0, i, 16'(6 + i));
        for (int i = 0; i < 16; i++) rd_push(1, i, 16'(16'h8006 + i));
        rd_drain("t1_rd_drain");
        // trigger and data while DONE are ignored
        beat(1'b1, 1'b1, 1'b0);
        check("done_trig_ignored", 32'(trig_count_o), 32'd1);
        check("done_hold", 32'(state_o), 32'd3);

        // 2: early trigger ignored, then accepted
        arm(2'b11, 4'd8);
        check("t2_rearm_done_clr", 32'(done_o), 32'd0);
        repeat (3) beat(1'b1, 1'b0, 1'b1);
        beat(1'b1, 1'b1, 1'b1);
        check("t2_ign_state", 32'(state_o), 32'd1);
        check("t2_ign_tcnt", 32'(trig_count_o), 32'd1);
        repeat (4) beat(1'b1, 1'b0, 1'b1);
        trig_wr = exp_wr;
        t3 = ramp;
        beat(1'b1, 1'b1, 1'b1);
        check("t2_acc_state", 32'(state_o), 32'd2);
        check("t2_acc_tcnt", 32'(trig_count_o), 32'd2);
        s3 = (trig_wr - 8) & 15;
        check("t2_start", 32'(start_addr_o), 32'(s3));

        // 3: gapped valid during TRIGGERED, 7 more post beats
        for (int i = 0; i < 7; i++) begin
            beat(1'b0, 1'b0, 1'b0);
            if (i == 6) check("t3_not_done_early", 32'(state_o), 32'd2);
            beat(1'b1, 1'b0, 1'b1);
        end
        check("t3_done_state", 32'(state_o), 32'd3);
        for (int i = 0; i < 16; i++) rd_push(0, i, 16'(t3 - 8 + i));
        for (int i = 0; i < 16; i++) rd_push(1, i, 16'(16'h8000 + t3 - 8 + i));
        rd_drain("t3_rd_drain");

        // 4: only ch0 recorded, ch1 keeps previous capture
        ramp = ramp + 16'h0100;
        b4 = ramp;
        arm(2'b01, 4'd0);
        trig_wr = exp_wr;
        beat(1'b1, 1'b1, 1'b1);
        repeat (15) beat(1'b1, 1'b0, 1'b1);
        check("t4_done_state", 32'(state_o), 32'd3);
        s4 = trig_wr & 15;
        check("t4_start", 32'(start_addr_o), 32'(s4));
        for (int i = 0; i < 16; i++) rd_push(0, i, 16'(b4 + i));
        for (int i = 0; i < 16; i++) begin
            p = (s4 + i) & 15;
            rd_push(1, i, 16'(16'h8000 + t3 - 8 + ((p - s3) & 15)));
        end
        rd_drain("t4_rd_drain");

        // 5: abort beats trigger, then async reset mid-capture
        arm(2'b11, 4'd2);
        repeat (3) beat(1'b1, 1'b0, 1'b1);
        abort_i = 1'b1; trig_i = 1'b1; adc_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        abort_i = 1'b0; trig_i = 1'b0;
        check("t5_abort_state", 32'(state_o), 32'd0);
        check("t5_abort_tcnt", 32'(trig_count_o), 32'd3);
        check("t5_abort_start_kept", 32'(start_addr_o), 32'(s4));
        arm(2'b11, 4'd0);
        beat(1'b1, 1'b1, 1'b1);
        repeat (3) beat(1'b1, 1'b0, 1'b1);
        check("t5_trig_state", 32'(state_o), 32'd2);
        #2;
        aresetn = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        @(negedge aclk);
        aresetn = 1'b1;
        exp_wr = 0;
        @(posedge aclk);
        #1;

        // 6: wrap with pretrig 15 triggered at wr_ptr 3
        arm(2'b11, 4'd15);
        repeat (19) beat(1'b1, 1'b0, 1'b1);
        trig_wr = exp_wr;
        t6 = ramp;
        beat(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4 && state_o != 2'd3; i++) beat(1'b0, 1'b0, 1'b0);
        check("t6_done_state", 32'(state_o), 32'd3);
        check("t6_start", 32'(start_addr_o), 32'((trig_wr - 15) & 15));
        check("t6_start_abs", 32'(start_addr_o), 32'd4);
        check("t6_tcnt", 32'(trig_count_o), 32'd1);
        for (int i = 0; i < 16; i++) rd_push(0, i, 16'(t6 - 15 + i));
        rd_push(1, 15, 16'(16'h8000 + t6));
        rd_drain("t6_rd_drain");

        // trigger counter saturation
        #2;
        force dut.trig_count_q = 16'hFFFE;
        #1;
        release dut.trig_count_q;
        @(posedge aclk);
        #1;
        arm(2'b11, 4'd0);
        beat(1'b1, 1'b1, 1'b1);
        check("sat_first", 32'(trig_count_o), 32'hFFFF);
        repeat (15) beat(1'b1, 1'b0, 1'b1);
        check("sat_done", 32'(state_o), 32'd3);
        arm(2'b11, 4'd0);
        beat(1'b1, 1'b1, 1'b1);
        check("sat_hold", 32'(trig_count_o), 32'hFFFF);
        check("sat_trig_state", 32'(state_o), 32'd2);

        repeat (2) @(posedge aclk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
